// File: rtl/pong_pkg.sv
// Shared types and screen constants for the pong game sequencer.
// Internal FSM states plus the 2-bit code reported on game_state.
package pong_pkg;

  localparam int SCREEN_W = 640;
  localparam int SCREEN_H = 480;
  localparam int BALL_CX  = SCREEN_W / 2;
  localparam int BALL_CY  = SCREEN_H / 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SERVE,
    ST_PLAY,
    ST_POINT,
    ST_OVER
  } game_state_t;

  // POINT is a hidden 1-cycle step and is reported as PLAY.
  function automatic logic [1:0] state_code(game_state_t s);
    logic [1:0] c;
    c = 2'd0;
    unique case (s)
      ST_IDLE:  c = 2'd0;
      ST_SERVE: c = 2'd1;
      ST_PLAY:  c = 2'd2;
      ST_POINT: c = 2'd2;
      ST_OVER:  c = 2'd3;
      default:  c = 2'd0;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pong_tick_div.sv
// Ball step divider: modulo-TICK_DIV counter, held at 0 when disabled.
// Emits a registered 1-cycle pulse in the cycle after each wrap.
module pong_tick_div #(
  parameter int TICK_DIV = 262144
) (
  input  logic clk,
  input  logic reset_n,
  input  logic en_i,
  output logic wrap_o
);

  localparam int CW = $clog2(TICK_DIV);
  localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          wrap_q, wrap_d;

  // Next count and wrap pulse; disabling clears both.
  always_comb begin
    cnt_d  = '0;
    wrap_d = 1'b0;
    if (en_i) begin
      if (cnt_q == LAST) begin
        wrap_d = 1'b1;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Counter and pulse registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      cnt_q  <= '0;
      wrap_q <= 1'b0;
    end else begin
      cnt_q  <= cnt_d;
      wrap_q <= wrap_d;
    end
  end

  assign wrap_o = wrap_q;

endmodule

// File: rtl/pong_game_ctrl.sv
// Pong game sequencer: start, serve delay, goal detection, scoring,
// game over, and the ball mover's step enable and recentre load.
module pong_game_ctrl
  import pong_pkg::*;
#(
  parameter int TICK_DIV           = 262144,
  parameter int LEFT_GOAL_X        = 20,
  parameter int RIGHT_GOAL_X       = SCREEN_W - 20,
  parameter int WIN_SCORE          = 7,
  parameter int SERVE_DELAY_FRAMES = 60
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       start_btn,
  input  logic       frame_tick,
  input  logic [9:0] ball_x_pos,
  input  logic [9:0] ball_y_pos,
  output logic       ball_step_en,
  output logic       ball_load,
  output logic       serve_dir_right,
  output logic [3:0] score_left,
  output logic [3:0] score_right,
  output logic [1:0] game_state,
  output logic       winner_left
);

  localparam logic [9:0] LGOAL = 10'(LEFT_GOAL_X);
  localparam logic [9:0] RGOAL = 10'(RIGHT_GOAL_X);
  localparam logic [3:0] WIN   = 4'(WIN_SCORE);
  localparam logic [7:0] DLY   = 8'(SERVE_DELAY_FRAMES);

  game_state_t state_q, state_d;
  logic [7:0]  delay_q, delay_d;
  logic [3:0]  sl_q, sl_d, sr_q, sr_d;
  logic        load_q, load_d;
  logic        dir_q, dir_d;
  logic        win_q, win_d;
  logic        ptr_q, ptr_d;
  logic [1:0]  gs_q;
  logic        sync1_q, sync2_q, prev_q;
  logic        start;
  logic        goal_l, goal_r, play_en;
  logic        unused_y;

  assign unused_y = ^ball_y_pos;

  assign start   = sync2_q & ~prev_q;
  assign goal_l  = ball_x_pos <= LGOAL;
  assign goal_r  = ball_x_pos >= RGOAL;
  assign play_en = (state_q == ST_PLAY) & ~(goal_l | goal_r);

  pong_tick_div #(
    .TICK_DIV(TICK_DIV)
  ) u_div (
    .clk    (clk),
    .reset_n(reset_n),
    .en_i   (play_en),
    .wrap_o (ball_step_en)
  );

  // Start button synchroniser and rising-edge history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      prev_q  <= 1'b0;
    end else begin
      sync1_q <= start_btn;
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
    end
  end

  // Next state, scores and registered output values.
  always_comb begin
    state_d = state_q;
    delay_d = delay_q;
    sl_d    = sl_q;
    sr_d    = sr_q;
    load_d  = 1'b0;
    dir_d   = dir_q;
    win_d   = win_q;
    ptr_d   = ptr_q;
    unique case (state_q)
      ST_IDLE, ST_OVER: begin
        if (start) begin
          sl_d    = '0;
          sr_d    = '0;
          dir_d   = 1'b1;
          win_d   = 1'b0;
          load_d  = 1'b1;
          delay_d = DLY;
          state_d = ST_SERVE;
        end
      end
      ST_SERVE: begin
        if (delay_q == '0) begin
          state_d = ST_PLAY;
        end else if (frame_tick) begin
          delay_d = delay_q - 8'd1;
        end
      end
      ST_PLAY: begin
        if (goal_l) begin
          sr_d    = sr_q + 4'd1;
          ptr_d   = 1'b1;
          state_d = ST_POINT;
        end else if (goal_r) begin
          sl_d    = sl_q + 4'd1;
          ptr_d   = 1'b0;
          state_d = ST_POINT;
        end
      end
      ST_POINT: begin
        if (sl_q == WIN || sr_q == WIN) begin
          win_d   = (sl_q == WIN);
          state_d = ST_OVER;
        end else begin
          dir_d   = ~ptr_q;
          load_d  = 1'b1;
          delay_d = DLY;
          state_d = ST_SERVE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Game state registers, cleared immediately by reset.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      delay_q <= '0;
      sl_q    <= '0;
      sr_q    <= '0;
      load_q  <= 1'b0;
      dir_q   <= 1'b1;
      win_q   <= 1'b0;
      ptr_q   <= 1'b0;
      gs_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      delay_q <= delay_d;
      sl_q    <= sl_d;
      sr_q    <= sr_d;
      load_q  <= load_d;
      dir_q   <= dir_d;
      win_q   <= win_d;
      ptr_q   <= ptr_d;
      gs_q    <= state_code(state_d);
    end
  end

  assign ball_load       = load_q;
  assign serve_dir_right = dir_q;
  assign score_left      = sl_q;
  assign score_right     = sr_q;
  assign game_state      = gs_q;
  assign winner_left     = win_q;

endmodule

// File: tb/tb_pong_game_ctrl.sv
// Directed bench for pong_game_ctrl: table-driven serve/play/goal
// flow plus hand sequences for game over, held button and reset.
module tb_pong_game_ctrl;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       start_btn;
  logic       frame_tick;
  logic [9:0] ball_x_pos;
  logic [9:0] ball_y_pos;
  logic       ball_step_en;
  logic       ball_load;
  logic       serve_dir_right;
  logic [3:0] score_left;
  logic [3:0] score_right;
  logic [1:0] game_state;
  logic       winner_left;

  int total = 0;
  int bad   = 0;
  int n_load = 0;
  int n_step = 0;

  always #5 clk = ~clk;

  pong_game_ctrl #(
    .TICK_DIV          (4),
    .LEFT_GOAL_X       (20),
    .RIGHT_GOAL_X      (620),
    .WIN_SCORE         (3),
    .SERVE_DELAY_FRAMES(2)
  ) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .start_btn      (start_btn),
    .frame_tick     (frame_tick),
    .ball_x_pos     (ball_x_pos),
    .ball_y_pos     (ball_y_pos),
    .ball_step_en   (ball_step_en),
    .ball_load      (ball_load),
    .serve_dir_right(serve_dir_right),
    .score_left     (score_left),
    .score_right    (score_right),
    .game_state     (game_state),
    .winner_left    (winner_left)
  );

  typedef struct {
    logic       st;
    logic       ft;
    logic [9:0] x;
    logic       ld;
    logic       stp;
    logic [1:0] gs;
    logic [3:0] sl;
    logic [3:0] sr;
    logic       dir;
  } vec_t;

  vec_t tv[26];

  function automatic vec_t mk(int st, int ft, int x, int ld, int stp,
                              int gs, int sl, int sr, int dir);
    vec_t v;
    v.st  = st[0];
    v.ft  = ft[0];
    v.x   = 10'(x);
    v.ld  = ld[0];
    v.stp = stp[0];
    v.gs  = 2'(gs);
    v.sl  = 4'(sl);
    v.sr  = 4'(sr);
    v.dir = dir[0];
    return v;
  endfunction

  task automatic chk(string nm, logic [15:0] act, logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d t=%0t", nm, act, exp, $time);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
    if (ball_load) n_load++;
    if (ball_step_en) n_step++;
  endtask

  task automatic serve_to_play();
    int k;
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0; cyc();
    frame_tick = 1'b1; cyc();
    frame_tick = 1'b0;
    k = 0;
    while (game_state != 2'd2 && k < 10) begin
      cyc();
      k++;
    end
    chk("to_play", 16'(game_state), 16'd2);
  endtask

  task automatic goal(int x);
    ball_x_pos = 10'(x);
    cyc();
    ball_x_pos = 10'd320;
    cyc();
  endtask

  task automatic chk_reset_vals(string nm);
    chk({nm, "_gs"}, 16'(game_state), 16'd0);
    chk({nm, "_sl"}, 16'(score_left), 16'd0);
    chk({nm, "_sr"}, 16'(score_right), 16'd0);
    chk({nm, "_step"}, 16'(ball_step_en), 16'd0);
    chk({nm, "_load"}, 16'(ball_load), 16'd0);
    chk({nm, "_dir"}, 16'(serve_dir_right), 16'd1);
    chk({nm, "_win"}, 16'(winner_left), 16'd0);
  endtask

  initial begin
    tv[0]  = mk(1, 0, 320, 0, 0, 0, 0, 0, 1);
    tv[1]  = mk(1, 0, 320, 0, 0, 0, 0, 0, 1);
    tv[2]  = mk(1, 0, 320, 1, 0, 1, 0, 0, 1);
    tv[3]  = mk(1, 0, 320, 0, 0, 1, 0, 0, 1);
    tv[4]  = mk(0, 1, 320, 0, 0, 1, 0, 0, 1);
    tv[5]  = mk(0, 0, 320, 0, 0, 1, 0, 0, 1);
    tv[6]  = mk(0, 1, 320, 0, 0, 1, 0, 0, 1);
    tv[7]  = mk(0, 0, 320, 0, 0, 2, 0, 0, 1);
    tv[8]  = mk(0, 0, 320, 0, 0, 2, 0, 0, 1);
    tv[9]  = mk(0, 0, 320, 0, 0, 2, 0, 0, 1);
    tv[10] = mk(0, 0, 320, 0, 0, 2, 0, 0, 1);
    tv[11] = mk(0, 0, 320, 0, 1, 2, 0, 0, 1);
    tv[12] = mk(0, 0, 320, 0, 0, 2, 0, 0, 1);
    tv[13] = mk(0, 0, 320, 0, 0, 2, 0, 0, 1);
    tv[14] = mk(0, 0, 320, 0, 0, 2, 0, 0, 1);
    tv[15] = mk(0, 0, 320, 0, 1, 2, 0, 0, 1);
    tv[16] = mk(0, 0, 20,  0, 0, 2, 0, 1, 1);
    tv[17] = mk(0, 0, 320, 1, 0, 1, 0, 1, 0);
    tv[18] = mk(0, 1, 320, 0, 0, 1, 0, 1, 0);
    tv[19] = mk(0, 1, 320, 0, 0, 1, 0, 1, 0);
    tv[20] = mk(0, 0, 320, 0, 0, 2, 0, 1, 0);
    tv[21] = mk(0, 0, 320, 0, 0, 2, 0, 1, 0);
    tv[22] = mk(0, 0, 320, 0, 0, 2, 0, 1, 0);
    tv[23] = mk(0, 0, 320, 0, 0, 2, 0, 1, 0);
    tv[24] = mk(0, 0, 1010, 0, 0, 2, 1, 1, 0);
    tv[25] = mk(0, 0, 320, 1, 0, 1, 1, 1, 1);

    reset_n    = 1'b0;
    start_btn  = 1'b0;
    frame_tick = 1'b0;
    ball_x_pos = 10'd320;
    ball_y_pos = 10'd240;
    cyc();
    cyc();
    chk_reset_vals("rst");
    reset_n = 1'b1;
    cyc();
    chk("rel_load", 16'(ball_load), 16'd0);
    chk("rel_step", 16'(ball_step_en), 16'd0);

    for (int i = 0; i < 26; i++) begin
      start_btn  = tv[i].st;
      frame_tick = tv[i].ft;
      ball_x_pos = tv[i].x;
      cyc();
      chk($sformatf("v%0d_load", i), 16'(ball_load), 16'(tv[i].ld));
      chk($sformatf("v%0d_step", i), 16'(ball_step_en), 16'(tv[i].stp));
      chk($sformatf("v%0d_gs", i), 16'(game_state), 16'(tv[i].gs));
      chk($sformatf("v%0d_sl", i), 16'(score_left), 16'(tv[i].sl));
      chk($sformatf("v%0d_sr", i), 16'(score_right), 16'(tv[i].sr));
      chk($sformatf("v%0d_dir", i), 16'(serve_dir_right), 16'(tv[i].dir));
    end
    frame_tick = 1'b0;
    ball_x_pos = 10'd320;

    serve_to_play();
    goal(20);
    chk("g2_sr", 16'(score_right), 16'd2);
    chk("g2_load", 16'(ball_load), 16'd1);
    serve_to_play();
    goal(20);
    chk("over_gs", 16'(game_state), 16'd3);
    chk("over_win", 16'(winner_left), 16'd0);
    chk("over_sr", 16'(score_right), 16'd3);
    chk("over_sl", 16'(score_left), 16'd1);
    chk("over_load", 16'(ball_load), 16'd0);
    n_load = 0;
    n_step = 0;
    for (int i = 0; i < 20; i++) begin
      frame_tick = (i % 3 == 0);
      cyc();
    end
    frame_tick = 1'b0;
    chk("over_nstep", 16'(n_step), 16'd0);
    chk("over_nload", 16'(n_load), 16'd0);
    chk("over_hold_gs", 16'(game_state), 16'd3);

    n_load = 0;
    start_btn = 1'b1;
    repeat (100) cyc();
    chk("restart_loads", 16'(n_load), 16'd1);
    chk("restart_gs", 16'(game_state), 16'd1);
    chk("restart_sl", 16'(score_left), 16'd0);
    chk("restart_sr", 16'(score_right), 16'd0);
    chk("restart_dir", 16'(serve_dir_right), 16'd1);

    start_btn = 1'b0;
    repeat (3) cyc();
    n_load = 0;
    start_btn = 1'b1;
    repeat (20) cyc();
    start_btn = 1'b0;
    chk("serve_press_gs", 16'(game_state), 16'd1);
    chk("serve_press_load", 16'(n_load), 16'd0);

    serve_to_play();
    goal(620);
    chk("gl1_sl", 16'(score_left), 16'd1);
    chk("gl1_dir", 16'(serve_dir_right), 16'd1);
    serve_to_play();
    goal(620);
    serve_to_play();
    goal(20);
    serve_to_play();
    cyc();
    cyc();
    chk("pre_rst_sl", 16'(score_left), 16'd2);
    chk("pre_rst_sr", 16'(score_right), 16'd1);
    reset_n = 1'b0;
    #1;
    chk_reset_vals("midrst");
    cyc();
    reset_n = 1'b1;
    n_step = 0;
    n_load = 0;
    for (int i = 0; i < 30; i++) begin
      frame_tick = (i % 4 == 0);
      cyc();
    end
    frame_tick = 1'b0;
    chk("post_rst_nstep", 16'(n_step), 16'd0);
    chk("post_rst_nload", 16'(n_load), 16'd0);
    chk("post_rst_gs", 16'(game_state), 16'd0);

    n_load = 0;
    start_btn = 1'b1;
    repeat (100) cyc();
    start_btn = 1'b0;
    chk("idle_hold_loads", 16'(n_load), 16'd1);
    chk("idle_hold_gs", 16'(game_state), 16'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
